// File: rtl/uart_rx_if.sv
// Serial-receive bundle between the line/consumer side and uart_rx.
// UART_RX_PARITY_EN adds the parity_err pulse.
interface uart_rx_if;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport master (input rx_in, output rx_data, output rx_valid, output frame_err,
                  output rx_busy, output parity_err);
  modport slave  (output rx_in, input rx_data, input rx_valid, input frame_err,
                  input rx_busy, input parity_err);
`else
  modport master (input rx_in, output rx_data, output rx_valid, output frame_err,
                  output rx_busy);
  modport slave  (output rx_in, input rx_data, input rx_valid, input frame_err,
                  input rx_busy);
`endif
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling; one-cycle rx_valid / frame_err pulses.
// UART_RX_PARITY_EN switches the frame to 8E1 and adds parity_err.
module uart_rx #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.master bus
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] BREAK  = 3'd4;
  localparam logic [2:0] PARITY = 3'd5;

  logic          rx_meta;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
`endif

  // Line idles high, so the synchronizer resets to 1 to avoid a phantom start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx_in;
      rx_s    <= rx_meta;
    end
  end

  assign bus.rx_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      bus.rx_data   <= '0;
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit        <= 1'b0;
      bus.parity_err <= 1'b0;
`endif
    end else begin
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            clk_cnt <= '0;
          end
        end
        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt        <= '0;
            shreg[bit_cnt] <= rx_s;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (^{shreg, par_bit}) begin
                bus.parity_err <= 1'b1;
              end else begin
                bus.rx_data  <= shreg;
                bus.rx_valid <= 1'b1;
              end
`else
              bus.rx_data  <= shreg;
              bus.rx_valid <= 1'b1;
`endif
            end else begin
              bus.frame_err <= 1'b1;
              state         <= BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        // A line held low after a bad stop bit must return high before a new frame.
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx at CLKS_PER_BIT=2 and 16.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if if2 ();
  uart_rx_if if16 ();

  uart_rx #(.CLKS_PER_BIT(2))  dut2  (.clk(clk), .rst(rst), .bus(if2));
  uart_rx #(.CLKS_PER_BIT(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  typedef struct {
    int         kind;   // 0 good byte, 1 frame error, 2 parity error
    logic [7:0] data;   // byte expected on rx_data when the event shows
    int         t0;     // cycle stamp of the start-bit falling edge
    int         lat;    // nominal frame length in clk up to the stop mid-sample
  } ev_t;

  ev_t        q2[$];
  ev_t        q16[$];
  logic [7:0] last2  = 8'h00;
  logic [7:0] last16 = 8'h00;
  int         checks = 0;
  int         passed = 0;

  function automatic int cpb(input int d);
    return (d == 0) ? 2 : 16;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  task automatic set_line(input int d, input logic v);
    if (d == 0) if2.rx_in = v;
    else        if16.rx_in = v;
  endtask

  task automatic hold(input int d, input logic v, input int bits);
    set_line(d, v);
    repeat (bits * cpb(d)) @(negedge clk);
  endtask

  // Model: stop low -> frame error; bad parity -> parity error; else the byte.
  task automatic send(input int d, input logic [7:0] b, input logic stopb, input logic good_par);
    ev_t  e;
    logic par;
    par   = good_par ? ^b : ~^b;
    e.t0  = cyc;
    e.lat = 19 * cpb(d) / 2;
`ifdef UART_RX_PARITY_EN
    e.lat = e.lat + cpb(d);
`endif
    if (!stopb) begin
      e.kind = 1;
      e.data = (d == 0) ? last2 : last16;
`ifdef UART_RX_PARITY_EN
    end else if (!good_par) begin
      e.kind = 2;
      e.data = (d == 0) ? last2 : last16;
`endif
    end else begin
      e.kind = 0;
      e.data = b;
      if (d == 0) last2 = b;
      else        last16 = b;
    end
    if (d == 0) q2.push_back(e);
    else        q16.push_back(e);
    hold(d, 1'b0, 1);
    for (int i = 0; i < 8; i++) hold(d, b[i], 1);
`ifdef UART_RX_PARITY_EN
    hold(d, par, 1);
`endif
    hold(d, stopb, 1);
  endtask

  task automatic mon(input int d, input logic v, input logic fe, input logic pe,
                     input logic [7:0] data);
    ev_t e;
    int  sz;
    int  diff2;
    string tag;
    tag = (d == 0) ? "c2" : "c16";
    if (v || fe || pe) begin
      chk({tag, "_one_pulse"}, int'(v) + int'(fe) + int'(pe), 1);
      sz = (d == 0) ? q2.size() : q16.size();
      chk({tag, "_event_expected"}, int'(sz > 0), 1);
      if (sz > 0) begin
        e = (d == 0) ? q2.pop_front() : q16.pop_front();
        chk({tag, "_kind"}, v ? 0 : (fe ? 1 : 2), e.kind);
        chk({tag, "_rx_data"}, int'(data), int'(e.data));
        // pulse rises at the previous posedge; measured in half-cycles from the line edge
        diff2 = 2 * (cyc - e.t0) - 1;
        checks++;
        if (diff2 >= 2 * (e.lat + 2) - 2 && diff2 <= 2 * (e.lat + 2) + 2) passed++;
        else $display("FAIL %s_latency: got %0d half-clk want %0d +/-2", tag, diff2, 2 * (e.lat + 2));
      end
    end
  endtask

  always @(negedge clk) begin
    logic pe2, pe16;
`ifdef UART_RX_PARITY_EN
    pe2  = if2.parity_err;
    pe16 = if16.parity_err;
`else
    pe2  = 1'b0;
    pe16 = 1'b0;
`endif
    if (!rst) begin
      mon(0, if2.rx_valid, if2.frame_err, pe2, if2.rx_data);
      mon(1, if16.rx_valid, if16.frame_err, pe16, if16.rx_data);
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((q2.size() != 0 || q16.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q2.size() + q16.size(), 0);
  endtask

  task automatic chk_reset_vals(input string tag, input logic [7:0] data, input logic v,
                                input logic fe, input logic busy);
    chk({tag, "_rst_rx_data"}, int'(data), 0);
    chk({tag, "_rst_rx_valid"}, int'(v), 0);
    chk({tag, "_rst_frame_err"}, int'(fe), 0);
    chk({tag, "_rst_rx_busy"}, int'(busy), 0);
  endtask

  initial begin
    logic [7:0] b;
    logic       stopb;
    if2.rx_in  = 1'b1;
    if16.rx_in = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("c2", if2.rx_data, if2.rx_valid, if2.frame_err, if2.rx_busy);
    chk_reset_vals("c16", if16.rx_data, if16.rx_valid, if16.frame_err, if16.rx_busy);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single byte, then idle
    send(0, 8'hA5, 1'b1, 1'b1);
    hold(0, 1'b1, 2);
    drain();
    chk("c2_busy_after_a5", int'(if2.rx_busy), 0);

    // back-to-back with no idle gap
    send(0, 8'h00, 1'b1, 1'b1);
    send(0, 8'hFF, 1'b1, 1'b1);
    send(0, 8'h55, 1'b1, 1'b1);
    hold(0, 1'b1, 2);
    drain();

    // randomized frames, occasional bad stop bits and random gaps
    for (int i = 0; i < 24; i++) begin
      b     = 8'($urandom);
      stopb = ($urandom_range(0, 4) != 0);
      send(0, b, stopb, 1'b1);
      if (!stopb) hold(0, 1'b1, 2);
      else        hold(0, 1'b1, $urandom_range(0, 2));
    end
    for (int i = 0; i < 4; i++) begin
      send(1, 8'($urandom), 1'b1, 1'b1);
      hold(1, 1'b1, $urandom_range(0, 1));
    end
    hold(1, 1'b1, 1);
    drain();

    // one-clock glitch is rejected at the start-bit mid-sample
    set_line(1, 1'b0);
    @(negedge clk);
    set_line(1, 1'b1);
    repeat (4) @(negedge clk);
    chk("glitch_busy_mid", int'(if16.rx_busy), 1);
    repeat (40) @(negedge clk);
    chk("glitch_busy_after", int'(if16.rx_busy), 0);

    // bad stop bit, line held low, then recovery
    send(1, 8'hE7, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    chk("break_busy_low", int'(if16.rx_busy), 1);
    hold(1, 1'b1, 2);
    send(1, 8'h3C, 1'b1, 1'b1);
    hold(1, 1'b1, 2);
    drain();

    // reset while bit 4 of 8'hC3 is on the line
    b = 8'hC3;
    hold(1, 1'b0, 1);
    for (int i = 0; i < 4; i++) hold(1, b[i], 1);
    set_line(1, b[4]);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    set_line(1, 1'b1);
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    last2  = 8'h00;
    last16 = 8'h00;
    chk_reset_vals("c16_mid", if16.rx_data, if16.rx_valid, if16.frame_err, if16.rx_busy);
    hold(1, 1'b1, 1);
    send(1, 8'h81, 1'b1, 1'b1);
    hold(1, 1'b1, 2);
    drain();

`ifdef UART_RX_PARITY_EN
    send(1, 8'h07, 1'b1, 1'b1);
    hold(1, 1'b1, 1);
    send(1, 8'h07, 1'b1, 1'b0);
    hold(1, 1'b1, 2);
    drain();
`endif

    chk("c2_idle_end", int'(if2.rx_busy), 0);
    chk("c16_idle_end", int'(if16.rx_busy), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
